arb_mux_n: RTL and testbench
============================

Name: arb_mux_n

Overview:
- Parametrised successor to the fixed-width 2/3/7-input muxes used in the multicycle datapath.
- Selects one of NUM WIDTH-bit input channels, either by an explicit select or by round-robin arbitration over channel valids.
- Registers the winning beat into a single-entry output stage with a valid/ready handshake.
- Used where several datapath sources (PC, ALUOut, MDR, immediate, etc.) share one sink across multiple cycles.

Parameters:
- WIDTH, 32, data width of each channel and of out_data.
- NUM, 7, number of input channels; 2 <= NUM <= 2**SEL_W.
- SEL_W, 3, width of sel and out_src.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM*WIDTH  channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- in_valid  input  NUM  per-channel beat valid.
- in_ready  output  NUM  per-channel accept; at most one bit high per cycle.
- mode  input  1  0 = direct select via sel, 1 = round-robin.
- sel  input  SEL_W  channel index used in direct mode.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  sink accepts the beat.

Behaviour:
- Reset (async, any time including mid-transfer):
  - out_valid = 0, out_data = 0, out_src = 0, round-robin pointer = 0, in_ready = 0.
  - Any pending beat is discarded.
- load_ok = !out_valid || out_ready. The output register may load when empty or when draining in the same cycle.
- Grant (combinational, from current-cycle inputs):
  - Direct mode (mode=0):
    - Candidate = sel.
    - If sel >= NUM, no grant; all in_ready = 0 and nothing is loaded.
    - Otherwise grant = sel only if in_valid[sel] = 1.
    - Valids of other channels are ignored.
  - Round-robin mode (mode=1):
    - Grant = first i with in_valid[i] = 1, searching ptr, ptr+1, …, NUM-1, 0, …, ptr-1.
    - No valid channel means no grant.
- in_ready[g] = load_ok for granted channel g; all other bits are 0. A transfer on channel g occurs when in_valid[g] && in_ready[g].
- On a transfer at a rising clk:
  - out_data <= channel g data, out_src <= g, out_valid <= 1.
  - In round-robin mode, ptr <= (g == NUM-1) ? 0 : g+1.
- If out_valid && out_ready and no transfer occurs, out_valid <= 0. out_data and out_src hold their last values.
- If out_valid && !out_ready, the register holds out_data, out_src and out_valid stable; all in_ready = 0 (backpressure).
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle when out_ready is held high.
- The pointer updates only on round-robin transfers. Direct-mode transfers and mode switches leave ptr unchanged.
- A mode or sel change takes effect in the same cycle for the grant decision. It never alters a beat already in the output register.
- When NUM < 2**SEL_W, unused index values are never produced on out_src.

Optional Feature:
- Macro: ARB_MUX_BEATCNT_EN.
- Defined:
  - Adds output port beat_cnt, 16 bits.
  - Increments by 1 on every output handshake (out_valid && out_ready) and wraps from 16'hFFFF to 0.
  - Reset value is 0 (asynchronous with rst).
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-transfer: assert rst while out_valid=1, out_data=32'hDEADBEEF -> out_valid=0, out_data=0, out_src=0 immediately (before the next clk edge); after release the first round-robin grant starts at channel 0.
- Direct mode: mode=0, sel=3, in_valid=7'b0001000, ch3=32'h00000033, out_ready=1 -> in_ready=7'b0001000; next cycle out_data=32'h33, out_src=3, out_valid=1.
- Direct mode, out of range: NUM=7, sel=7, all in_valid=1 -> in_ready=0 for 3 cycles, out_valid stays 0.
- Round-robin fairness: mode=1, in_valid=7'b1111111 held, out_ready=1 -> out_src sequence 0,1,2,3,4,5,6,0 on consecutive cycles.
- Round-robin skip and wrap: ptr=5, in_valid=7'b0000110 -> grant ch1, then ch2, then ch1 again (ptr wraps past 6).
- Backpressure: out_valid=1 (src 2), out_ready=0 for 4 cycles with ch4 valid -> in_ready=0, out_data/out_src stable; on out_ready=1 the ch4 beat loads the same cycle, so there is no bubble. With ARB_MUX_BEATCNT_EN defined, beat_cnt increments by exactly 1 at that handshake.

Source files
------------

// File: rtl/arb_mux_n.sv
// N-input mux/arbiter: direct select or round-robin grant into a single registered output stage.
// Optional beat counter output enabled by defining ARB_MUX_BEATCNT_EN.
module arb_mux_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NUM   = 7,
    parameter int unsigned SEL_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM*WIDTH-1:0] in_data,
    input  logic [NUM-1:0]     in_valid,
    output logic [NUM-1:0]     in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
`ifdef ARB_MUX_BEATCNT_EN
   ,output logic [15:0]        beat_cnt
`endif
);

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_src_q, out_src_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic               load_ok;
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic [WIDTH-1:0]   grant_data;
    logic               xfer;

    assign load_ok = !out_valid_q || out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            // An out-of-range sel matches no channel, so it never grants.
            for (int unsigned i = 0; i < NUM; i++) begin
                if (sel == SEL_W'(i)) begin
                    grant_vld = in_valid[i];
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Search ptr..NUM-1 first, then wrap to 0..ptr-1.
            for (int unsigned i = 0; i < NUM; i++) begin
                if (!grant_vld && SEL_W'(i) >= ptr_q && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
            for (int unsigned i = 0; i < NUM; i++) begin
                if (!grant_vld && SEL_W'(i) < ptr_q && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end
    end

    assign xfer = grant_vld && load_ok && !rst;

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_src_d   = grant_idx;
            if (mode) begin
                ptr_d = (32'(grant_idx) == NUM - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef ARB_MUX_BEATCNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = (out_valid_q && out_ready) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench for arb_mux_n (NUM=7, WIDTH=32, SEL_W=3).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_arb_mux_n;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NUM   = 7;
    localparam int unsigned SEL_W = 3;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM*WIDTH-1:0] in_data;
    logic [NUM-1:0]       in_valid;
    logic [NUM-1:0]       in_ready;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_src;
    logic                 out_valid;
    logic                 out_ready;
`ifdef ARB_MUX_BEATCNT_EN
    logic [15:0]          beat_cnt;
`endif

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    arb_mux_n #(
        .WIDTH (WIDTH),
        .NUM   (NUM),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ARB_MUX_BEATCNT_EN
       ,.beat_cnt  (beat_cnt)
`endif
    );

    // Every output handshake must match the oldest expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_extra: got data=%h src=%0d, required no beat",
                         out_data, out_src);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.d || out_src !== e.s) begin
                    bad++;
                    $display("FAIL scoreboard_beat: got data=%h src=%0d, required data=%h src=%0d",
                             out_data, out_src, e.d, e.s);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic push(input int ch, input logic [WIDTH-1:0] v);
        beat_t e;
        e.d = v;
        e.s = SEL_W'(ch);
        exp_q.push_back(e);
    endtask

    task automatic check_ready(input string name, input logic [NUM-1:0] req);
        total++;
        if (in_ready !== req) begin
            bad++;
            $display("FAIL %s: in_ready=%b, required %b", name, in_ready, req);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [WIDTH-1:0] d,
                             input logic [SEL_W-1:0] s);
        total++;
        if (out_valid !== v || out_data !== d || out_src !== s) begin
            bad++;
            $display("FAIL %s: valid=%b data=%h src=%0d, required valid=%b data=%h src=%0d",
                     name, out_valid, out_data, out_src, v, d, s);
        end
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check_out("reset_state", 1'b0, '0, '0);
        check_ready("reset_ready", '0);
        step();
        rst = 1'b0;
        set_ch(0, 32'hDEADBEEF);
        in_valid = 7'b0000001;
        step();
        in_valid = '0;
        @(negedge clk);
        check_out("loaded_before_reset", 1'b1, 32'hDEADBEEF, 3'd0);
        #2;
        rst = 1'b1;
        in_valid = 7'b1111111;
        #1;
        check_out("async_reset_clears", 1'b0, '0, '0);
        check_ready("ready_in_reset", '0);
        step();
        rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check_ready("rr_first_after_reset", 7'b0000001);
        in_valid = '0;
        step();
    endtask

    task automatic test_direct();
        mode = 1'b0; sel = 3'd3; out_ready = 1'b1;
        set_ch(3, 32'h00000033);
        set_ch(2, 32'h00000022);
        in_valid = 7'b0001000;
        @(negedge clk);
        check_ready("direct_ready", 7'b0001000);
        push(3, 32'h00000033);
        step();
        in_valid = '0;
        @(negedge clk);
        check_out("direct_out", 1'b1, 32'h00000033, 3'd3);
        step();
    endtask

    task automatic test_direct_oor();
        mode = 1'b0; sel = 3'd7; in_valid = 7'b1111111; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_ready("oor_ready", '0);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL oor_valid: out_valid=%b, required 0", out_valid);
            end
            step();
        end
        in_valid = '0;
    endtask

    task automatic test_rr_fair();
        mode = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < int'(NUM); i++) set_ch(i, 32'hA0 + i);
        in_valid = 7'b1111111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_ready("rr_fair_ready", 7'(1 << (k % 7)));
            push(k % 7, 32'hA0 + (k % 7));
            step();
        end
        drain();
    endtask

    task automatic test_rr_wrap();
        int seq [3] = '{1, 2, 1};
        mode = 1'b1; out_ready = 1'b1;
        in_valid = 7'b0010000;
        @(negedge clk);
        check_ready("rr_to_ptr5", 7'b0010000);
        push(4, 32'hA4);
        step();
        in_valid = 7'b0000110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_ready("rr_wrap_ready", 7'(1 << seq[k]));
            push(seq[k], 32'hA0 + seq[k]);
            step();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] cnt0;
        mode = 1'b0; sel = 3'd2; out_ready = 1'b0;
        set_ch(2, 32'h00000222);
        set_ch(4, 32'h00000444);
        in_valid = 7'b0000100;
        @(negedge clk);
        check_ready("bp_first_ready", 7'b0000100);
        push(2, 32'h00000222);
        step();
        sel = 3'd4;
        in_valid = 7'b0010000;
`ifdef ARB_MUX_BEATCNT_EN
        cnt0 = beat_cnt;
`else
        cnt0 = '0;
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_ready("bp_stall_ready", '0);
            check_out("bp_hold", 1'b1, 32'h00000222, 3'd2);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_ready("bp_no_bubble", 7'b0010000);
        push(4, 32'h00000444);
        step();
        in_valid = '0;
        @(negedge clk);
        check_out("bp_second_beat", 1'b1, 32'h00000444, 3'd4);
`ifdef ARB_MUX_BEATCNT_EN
        total++;
        if (beat_cnt !== cnt0 + 16'd1) begin
            bad++;
            $display("FAIL beat_cnt: got %0d, required %0d", beat_cnt, cnt0 + 16'd1);
        end
`endif
        step();
        drain();
    endtask

    initial begin
        test_reset();
        test_direct();
        test_direct_oor();
        test_rr_fair();
        test_rr_wrap();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: %0d beats pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
